// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module : booth_mult_seq
// Desc   : Multi-cycle radix-2 Booth multiplier, signed/unsigned per transaction,
//          valid/ready handshakes on operands and product.
// Rev    : 1.0  initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);

    localparam int c_n  = WIDTH + 1;
    localparam int c_cw = $clog2(c_n + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_n:0]     r_acc;
    logic [c_n-1:0]   r_q;
    logic [c_n-1:0]   r_m;
    logic             r_qm1;
    logic [c_cw-1:0]  r_cnt;
    logic             r_out_valid;
    logic [2*WIDTH-1:0] r_prod;

    logic             w_accept;
    logic             w_last;
    logic [c_n-1:0]   w_a_ext;
    logic [c_n-1:0]   w_b_ext;
    logic [c_n:0]     w_m_ext;
    logic [c_n:0]     w_sum;
    logic [c_n:0]     w_acc_sh;
    logic [c_n-1:0]   w_q_sh;
    logic [2*WIDTH-1:0] w_prod_next;

    // The mode bit only matters for the extension, so it is folded into M and Q.
    assign w_a_ext  = {is_signed & a[WIDTH-1], a};
    assign w_b_ext  = {is_signed & b[WIDTH-1], b};
    assign w_m_ext  = {r_m[c_n-1], r_m};
    assign w_accept = (r_state == c_idle) && in_valid;
    assign w_last   = (r_cnt == c_last);

    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
    end

    assign w_acc_sh    = {w_sum[c_n], w_sum[c_n:1]};
    assign w_q_sh      = {w_sum[0], r_q[c_n-1:1]};
    assign w_prod_next = {w_acc_sh[WIDTH-2:0], w_q_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (in_valid)  w_next_state = c_calc;
            c_calc:  if (w_last)    w_next_state = c_done;
            c_done:  if (out_ready) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (r_state)
            c_idle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_q   <= w_b_ext;
            r_m   <= w_a_ext;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == c_calc) begin
            r_acc <= w_acc_sh;
            r_q   <= w_q_sh;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    // Product is captured on the final step and then frozen until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_prod      <= '0;
        end else if ((r_state == c_calc) && w_last) begin
            r_out_valid <= 1'b1;
            r_prod      <= w_prod_next;
        end else if ((r_state == c_done) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign prod      = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_booth_mult_seq
// Desc   : Directed and random checks of booth_mult_seq at WIDTH=4 and WIDTH=8.
// Rev    : 1.0  initial release
// ============================================================================
module tb_booth_mult_seq;

    logic        clk;
    logic        rst_n;

    logic        iv4, ir4, s4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] q4[$];
    logic [15:0] q8[$];

    booth_mult_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .is_signed(s4), .out_valid(ov4), .out_ready(or4), .prod(p4), .busy(busy4)
    );

    booth_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .prod(p8), .busy(busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
        longint ea, eb, mask;
        mask = (longint'(1) << w) - 1;
        ea = longint'(a) & mask;
        eb = longint'(b) & mask;
        if (s && a[w-1]) ea = ea - (longint'(1) << w);
        if (s && b[w-1]) eb = eb - (longint'(1) << w);
        return 16'((ea * eb) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 4) ? ir4 : ir8;
    endfunction

    function automatic logic get_ov(input int w);
        return (w == 4) ? ov4 : ov8;
    endfunction

    function automatic logic [15:0] get_prod(input int w);
        return (w == 4) ? {8'h00, p4} : p8;
    endfunction

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic send(input int w, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp);
        int cyc = 0;
        while (!get_ir(w) && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_before_send", 32'(get_ir(w)), 32'd1);
        if (w == 4) begin
            iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; s4 = s;
        end else begin
            iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        iv8 = 1'b0;
        if (w == 4) q4.push_back(exp);
        else        q8.push_back(exp);
    endtask

    task automatic wait_out(input int w, input int lat);
        int cyc = 0;
        logic [15:0] exp;
        while (!get_ov(w) && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_seen", 32'(get_ov(w)), 32'd1);
        if (lat >= 0) check("latency", 32'(cyc), 32'(lat));
        if (w == 4) begin
            if (q4.size() == 0) check("scoreboard4_empty", 32'd0, 32'd1);
            else begin exp = q4.pop_front(); check("prod4", 32'(get_prod(4)), 32'(exp)); end
        end else begin
            if (q8.size() == 0) check("scoreboard8_empty", 32'd0, 32'd1);
            else begin exp = q8.pop_front(); check("prod8", 32'(get_prod(8)), 32'(exp)); end
        end
    endtask

    task automatic xact(input int w, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input int lat);
        send(w, a, b, s, exp);
        wait_out(w, lat);
    endtask

    initial begin
        int seen;
        int last_out;
        logic [7:0]  ra, rb;
        logic        rs;
        logic [7:0]  held;

        rst_n = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
        #12;
        check("rst_out_valid4", 32'(ov4), 32'd0);
        check("rst_prod4", 32'(p4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_in_ready4", 32'(ir4), 32'd1);
        check("rst_prod8", 32'(p8), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        xact(4, 8'h09, 8'h08, 1'b1, 16'h0038, 5);
        xact(4, 8'h08, 8'h08, 1'b1, 16'h0040, 5);
        xact(4, 8'h08, 8'h07, 1'b1, 16'h00C8, 5);
        xact(4, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 5);
        xact(4, 8'h0F, 8'h0F, 1'b1, 16'h0001, 5);
        xact(8, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
        xact(8, 8'h80, 8'h80, 1'b1, 16'h4000, 9);
        xact(8, 8'h80, 8'h7F, 1'b1, 16'hC080, 9);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            xact(8, ra, rb, rs, ref_mul(8, ra, rb, rs), 9);
        end
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            xact(4, ra, rb, rs, ref_mul(4, ra, rb, rs), 5);
        end

        // Backpressure: result and valid frozen while the consumer stalls.
        @(posedge clk); #1;
        or4 = 1'b0;
        xact(4, 8'h06, 8'h0B, 1'b0, 16'h0042, 5);
        held = p4;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(ov4), 32'd1);
            check("bp_prod", 32'(p4), 32'(held));
            check("bp_in_ready", 32'(ir4), 32'd0);
        end
        or4 = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(ov4), 32'd0);

        // Operands presented during CALC must be ignored.
        send(4, 8'h03, 8'h05, 1'b0, 16'h000F);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; s4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("calc_in_ready", 32'(ir4), 32'd0);
        end
        iv4 = 1'b0;
        wait_out(4, -1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("no_extra_out", 32'(ov4), 32'd0);
        end

        // Back-to-back with in_valid held: one result every WIDTH+3 cycles.
        iv4 = 1'b1; a4 = 4'h3; b4 = 4'h5; s4 = 1'b0;
        seen = 0;
        last_out = -1;
        for (int c = 0; c < 60 && seen < 3; c++) begin
            if (ir4) q4.push_back(16'h000F);
            if (ov4) begin
                if (q4.size() == 0) check("b2b_empty", 32'd0, 32'd1);
                else check("b2b_prod", 32'(p4), 32'(q4.pop_front()));
                if (last_out >= 0) check("b2b_interval", 32'(c - last_out), 32'd7);
                last_out = c;
                seen++;
                if (seen == 3) iv4 = 1'b0;
            end
            if (seen < 3) begin @(posedge clk); #1; end
        end
        check("b2b_count", 32'(seen), 32'd3);
        check("b2b_queue_drained", 32'(q4.size()), 32'd0);
        @(posedge clk); #1;

        // Reset at step 2 of CALC aborts the transaction.
        send(4, 8'h07, 8'h07, 1'b1, 16'h0031);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(ov4), 32'd0);
        check("mid_rst_prod", 32'(p4), 32'd0);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_in_ready", 32'(ir4), 32'd1);
        q4.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("post_rst_idle", 32'(ov4), 32'd0);
            @(posedge clk); #1;
        end
        xact(4, 8'h03, 8'h05, 1'b0, 16'h000F, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
